// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues sequential PCs to imem_wrapper, pairs in-order
// responses with their PCs, buffers them for decode and handles redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_pc_o,
  input  logic        mem_rsp_valid_i,
  output logic        mem_rsp_ready_o,
  input  logic [31:0] mem_instr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_pc_o,
  output logic [31:0] fetch_instr_o
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned FW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {StBoot, StRun, StStall} state_e;

  state_e          state_q, state_d;
  logic [31:0]     next_pc_q, next_pc_d;
  logic            req_valid_q, req_valid_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic            req_stale_q, req_stale_d;
  logic            rsp_ready_q;
  logic [OutW-1:0] out_cnt_q, out_cnt_d;
  logic [OutW-1:0] drop_cnt_q, drop_cnt_d;
  logic [QW-1:0]   pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [FW-1:0]   fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [FCW-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic [31:0] pcq_mem    [MAX_OUTSTANDING];
  logic [31:0] fifo_pc    [FIFO_DEPTH];
  logic [31:0] fifo_instr [FIFO_DEPTH];

  logic            accept, rsp_fire, drop_rsp, fifo_push, fifo_pop, fifo_empty;
  logic            credit, req_hold;
  logic [SumW-1:0] occ_sum;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  function automatic logic [QW-1:0] pcq_inc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  assign accept     = req_valid_q & mem_req_ready_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire   = mem_rsp_valid_i & rsp_ready_q & (out_cnt_q != '0);
  assign drop_rsp   = rsp_fire & (drop_cnt_q != '0);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_push  = rsp_fire & ~drop_rsp & ~redirect_valid_i;
  assign fifo_pop   = ~fifo_empty & fetch_ready_i & ~redirect_valid_i;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (accept && !rsp_fire) begin
      out_cnt_d = out_cnt_q + OutW'(1);
    end else if (!accept && rsp_fire) begin
      out_cnt_d = out_cnt_q - OutW'(1);
    end

    pcq_wr_d = accept   ? pcq_inc(pcq_wr_q) : pcq_wr_q;
    pcq_rd_d = rsp_fire ? pcq_inc(pcq_rd_q) : pcq_rd_q;

    fifo_wr_d  = fifo_push ? fifo_wr_q + FW'(1) : fifo_wr_q;
    fifo_rd_d  = fifo_pop  ? fifo_rd_q + FW'(1) : fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push && !fifo_pop) begin
      fifo_cnt_d = fifo_cnt_q + FCW'(1);
    end else if (!fifo_push && fifo_pop) begin
      fifo_cnt_d = fifo_cnt_q - FCW'(1);
    end

    next_pc_d   = next_pc_q;
    drop_cnt_d  = drop_cnt_q;
    req_stale_d = req_stale_q;
    if (accept) begin
      // A stale request was fetched for the old path: drop its response, keep next_pc.
      if (req_stale_q) drop_cnt_d = drop_cnt_d + OutW'(1);
      else             next_pc_d  = next_pc_q + 32'd4;
      req_stale_d = 1'b0;
    end
    if (drop_rsp) drop_cnt_d = drop_cnt_d - OutW'(1);

    if (redirect_valid_i) begin
      next_pc_d   = {redirect_pc_i[31:2], 2'b00};
      drop_cnt_d  = out_cnt_d;
      req_stale_d = req_valid_q & ~accept;
      fifo_wr_d   = '0;
      fifo_rd_d   = '0;
      fifo_cnt_d  = '0;
    end

    occ_sum  = SumW'(out_cnt_d) + SumW'(fifo_cnt_d);
    credit   = (out_cnt_d < OutW'(MAX_OUTSTANDING)) && (occ_sum < SumW'(FIFO_DEPTH));
    req_hold = req_valid_q & ~accept;

    req_valid_d = req_hold | (credit & (state_q != StBoot));
    req_pc_d    = (req_valid_d && !req_hold) ? next_pc_d : req_pc_q;

    state_d = state_q;
    case (state_q)
      StBoot:         state_d = StRun;
      StRun, StStall: state_d = (req_hold || credit) ? StRun : StStall;
      default:        state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StBoot;
      next_pc_q   <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      req_stale_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      out_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      pcq_wr_q    <= '0;
      pcq_rd_q    <= '0;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      next_pc_q   <= next_pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      req_stale_q <= req_stale_d;
      rsp_ready_q <= 1'b1;
      out_cnt_q   <= out_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      pcq_wr_q    <= pcq_wr_d;
      pcq_rd_q    <= pcq_rd_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) pcq_mem[pcq_wr_q] <= req_pc_q;
    if (fifo_push) begin
      fifo_pc[fifo_wr_q]    <= pcq_mem[pcq_rd_q];
      fifo_instr[fifo_wr_q] <= mem_instr_i;
    end
  end

  assign mem_req_valid_o = req_valid_q;
  assign mem_pc_o        = req_pc_q;
  assign mem_rsp_ready_o = rsp_ready_q;
  assign fetch_valid_o   = ~fifo_empty;
  assign fetch_pc_o      = fifo_empty ? '0 : fifo_pc[fifo_rd_q];
  assign fetch_instr_o   = fifo_empty ? '0 : fifo_instr[fifo_rd_q];

`ifndef SYNTHESIS
  rsp_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rstn_i)
    mem_rsp_valid_i |-> (out_cnt_q != '0));
  out_cnt_bounded: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (out_cnt_q <= OutW'(MAX_OUTSTANDING)) && (drop_cnt_q <= out_cnt_q));
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer between the core front end and imem_wrapper.
- Generates sequential PCs and issues them over the imem_wrapper req valid/ready channel, with multiple requests in flight.
- Pairs in-order responses with their PCs and buffers them in a small FIFO for decode.
- On a redirect (branch/jump/trap), restarts fetch at a new PC and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first PC fetched after reset release.
- MAX_OUTSTANDING, 2, max requests accepted by memory and not yet responded (1..7).
- FIFO_DEPTH, 4, response buffer entries; power of 2, >= MAX_OUTSTANDING.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- redirect_valid_i  in  1  one-cycle pulse: restart fetch at redirect_pc_i.
- redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- mem_req_valid_o  out  1  request to imem_wrapper req_valid_i.
- mem_req_ready_i  in  1  from imem_wrapper req_ready_o.
- mem_pc_o  out  32  to imem_wrapper pc_i.
- mem_rsp_valid_i  in  1  from imem_wrapper rsp_valid_o.
- mem_rsp_ready_o  out  1  to imem_wrapper rsp_ready_i; constant 1 after reset.
- mem_instr_i  in  32  from imem_wrapper instr_o.
- fetch_valid_o  out  1  instruction available to decode.
- fetch_ready_i  in  1  decode accepts.
- fetch_pc_o  out  32  PC of the presented instruction.
- fetch_instr_o  out  32  presented instruction.

Behaviour:
- Reset (async assert, sync deassert):
  - mem_req_valid_o, fetch_valid_o, mem_rsp_ready_o = 0; fetch_pc_o, fetch_instr_o, mem_pc_o = 0.
  - next_pc = RESET_PC; all counters and the FIFO cleared; FSM = S_BOOT.
- FSM:
  - S_BOOT: one cycle, no requests, mem_rsp_ready_o goes to 1; always -> S_RUN.
  - S_RUN: issue while credit exists; -> S_STALL when credit = 0.
  - S_STALL: mem_req_valid_o = 0; -> S_RUN when credit returns.
  - Redirect is legal in any state except S_BOOT, where it is still captured into next_pc.
- Credit:
  - credit = (outstanding < MAX_OUTSTANDING) and (outstanding + fifo_count < FIFO_DEPTH).
  - Every response therefore always has a FIFO slot; mem_rsp_ready_o stays 1.
- Request:
  - mem_req_valid_o is registered; mem_pc_o = next_pc.
  - Once asserted, valid and mem_pc_o hold stable until mem_req_valid_o & mem_req_ready_i, even across a redirect.
  - On handshake: next_pc += 4 (mod 2^32, 0xFFFF_FFFC wraps to 0); the accepted PC is pushed into the in-flight PC queue (depth MAX_OUTSTANDING); outstanding += 1.
  - Earliest re-issue is the cycle after the handshake.
- Response:
  - On mem_rsp_valid_i: pop the PC queue; outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and discard the response.
  - Otherwise push {pc, instr} into the FIFO.
  - A response is visible on fetch_* the cycle after it arrives (FIFO registered, show-ahead).
- Output:
  - fetch_valid_o = FIFO not empty.
  - The entry pops on fetch_valid_o & fetch_ready_i.
  - Simultaneous push and pop are allowed at any count, including full and empty.
- Redirect (edge where redirect_valid_i = 1):
  - FIFO flushed; next_pc = {redirect_pc_i[31:2], 2'b00}.
  - drop_cnt = outstanding after this cycle's accept/response updates, so a same-cycle request handshake is counted as stale.
  - A request pending but not yet accepted is marked stale; when accepted, drop_cnt += 1 and next_pc is not incremented.
  - A response arriving in the redirect cycle counts as already removed from outstanding and is discarded.
  - A fetch pop in the same cycle is ignored, since the flush wins.
  - The first post-redirect request is issued no earlier than the next cycle, even with stale responses still pending.
- Invariants:
  - outstanding <= MAX_OUTSTANDING.
  - drop_cnt <= outstanding.
  - mem_rsp_valid_i with outstanding == 0 is a protocol error; assertion in simulation, ignored in RTL.
- Mid-operation reset discards all state immediately, including in-flight bookkeeping.

Test Plan:
- Reset release, RESET_PC=0, imem_wrapper ready/1-cycle latency, fetch_ready_i=1 -> fetch_pc_o sequence 0x0, 0x4, 0x8, 0xC with matching instr, no gaps once streaming, no request in the S_BOOT cycle.
- fetch_ready_i=0 for 20 cycles -> exactly FIFO_DEPTH=4 entries buffered, mem_req_valid_o=0 (S_STALL), no response lost; release -> resumes at 0x10.
- Redirect to 0x0000_0103 with 2 requests outstanding -> both stale responses dropped, FIFO empty, next fetch_pc_o = 0x100.
- Redirect in the same cycle as a request handshake and a response -> drop_cnt counts the new request; first delivered PC equals the redirect target.
- Redirect to 0xFFFF_FFF8 -> fetch_pc_o 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset asserted with 2 outstanding and 3 FIFO entries -> all outputs 0 at once; after release, fetch restarts at RESET_PC with no stale delivery.
